// File: rtl/sprite_reg_writer_pkg.sv
// Shared definitions for the sprite register write path: opcodes, sprite word
// layout, default screen limits and the writer FSM states.
package sprite_pkg;

    typedef enum logic [1:0] {
        OP_NOP       = 2'b00,
        OP_SET       = 2'b01,
        OP_CLEAR     = 2'b10,
        OP_CLEAR_ALL = 2'b11
    } sprite_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_SWEEP
    } wr_state_e;

    localparam logic [2:0]  STATUS_ACTIVE = 3'b001;

    localparam int unsigned STATUS_LSB = 29;
    localparam int unsigned X_MSB      = 28;
    localparam int unsigned X_LSB      = 19;
    localparam int unsigned Y_MSB      = 18;
    localparam int unsigned Y_LSB      = 9;
    localparam int unsigned OFF_MSB    = 8;
    localparam int unsigned OFF_LSB    = 0;

    localparam int unsigned X_MAX_DEFAULT = 640;
    localparam int unsigned Y_MAX_DEFAULT = 480;

    // Layout must match what the per-register comparators decode during scan-out.
    function automatic logic [31:0] sprite_word(input logic [9:0] x,
                                                input logic [9:0] y,
                                                input logic [8:0] offset);
        logic [31:0] w;
        w                     = '0;
        w[STATUS_LSB +: 3]    = STATUS_ACTIVE;
        w[X_MSB:X_LSB]        = x;
        w[Y_MSB:Y_LSB]        = y;
        w[OFF_MSB:OFF_LSB]    = offset;
        return w;
    endfunction

    function automatic wr_state_e state_for_op(input sprite_op_e op);
        return (op == OP_CLEAR_ALL) ? ST_SWEEP : ST_DRAIN;
    endfunction

endpackage

// File: rtl/sprite_reg_writer_if.sv
// Command channel from the CPU/instruction side into the sprite register writer.
interface sprite_reg_writer_if #(
    parameter int unsigned ADDR_W = 5
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [9:0]        cmd_x;
    logic [9:0]        cmd_y;
    logic [8:0]        cmd_offset;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_x, cmd_y, cmd_offset,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_x, cmd_y, cmd_offset,
        output cmd_ready
    );
endinterface

// File: rtl/sprite_reg_writer_cmd_fifo.sv
// Synchronous command FIFO; exposes the head entry plus the tag of the entry
// behind it so the writer can pick its next state on a pop.
module sprite_cmd_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 39,
    parameter  int unsigned TAG_W = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [TAG_W-1:0] next_tag,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] nxt_ptr;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign nxt_ptr  = rd_ptr_q + PTR_W'(1);
    assign head     = mem_q[rd_ptr_q];
    assign next_tag = mem_q[nxt_ptr][WIDTH-1 -: TAG_W];
    assign count    = count_q;

endmodule

// File: rtl/sprite_reg_writer.sv
// Sprite register bank write controller: buffers CPU sprite commands and drains
// them as formatted register words while the bank's write window is open.
module sprite_reg_writer
    import sprite_pkg::*;
#(
    parameter int unsigned SIZE_REG   = 32,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned X_MAX      = X_MAX_DEFAULT,
    parameter int unsigned Y_MAX      = Y_MAX_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    sprite_reg_writer_if.slave  cmd,
    input  logic                write_window,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [SIZE_REG-1:0] wr_data,
    output logic                busy,
    output logic                cmd_err
);
    localparam int unsigned ENTRY_W = 2 + ADDR_W + SIZE_REG;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        sprite_op_e          op;
        logic [ADDR_W-1:0]   addr;
        logic [SIZE_REG-1:0] word;
    } entry_t;

    entry_t           push_entry, head;
    logic [1:0]       next_tag;
    logic [CNT_W-1:0] count;
    logic             ready, accept, range_bad, push, pop;
    sprite_op_e       op_in;
    sprite_op_e       new_head_op;
    logic             new_head_valid;

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic              cmd_err_q, cmd_err_d;

    always_comb begin
        op_in     = sprite_op_e'(cmd.cmd_op);
        ready     = (count < CNT_W'(FIFO_DEPTH));
        range_bad = (32'(cmd.cmd_x) >= X_MAX) || (32'(cmd.cmd_y) >= Y_MAX);
        accept    = cmd.cmd_valid && ready;
        push      = accept && (op_in != OP_NOP) && !((op_in == OP_SET) && range_bad);
        cmd_err_d = accept && (op_in == OP_SET) && range_bad;

        push_entry.op   = op_in;
        push_entry.addr = cmd.cmd_addr;
        push_entry.word = (op_in == OP_SET)
                        ? SIZE_REG'(sprite_word(cmd.cmd_x, cmd.cmd_y, cmd.cmd_offset))
                        : '0;
    end

    assign cmd.cmd_ready = ready;

    always_comb begin
        sweep_d = sweep_q;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: ;
            ST_DRAIN: begin
                wr_en   = write_window;
                wr_addr = head.addr;
                wr_data = head.word;
                pop     = write_window;
            end
            ST_SWEEP: begin
                wr_en   = write_window;
                wr_addr = sweep_q;
                if (write_window) begin
                    if (sweep_q == ADDR_W'(NUM_REGS - 1)) begin
                        pop     = 1'b1;
                        sweep_d = '0;
                    end else begin
                        sweep_d = sweep_q + ADDR_W'(1);
                    end
                end
            end
            default: ;
        endcase
        // Registered state may still be active while reset is asserted; suppress the strobe.
        if (reset) begin
            wr_en = 1'b0;
            pop   = 1'b0;
        end

        // Next state follows whichever entry will sit at the FIFO head after this edge.
        if (count == '0) begin
            new_head_valid = push;
            new_head_op    = push_entry.op;
        end else if (!pop) begin
            new_head_valid = 1'b1;
            new_head_op    = head.op;
        end else if (count > CNT_W'(1)) begin
            new_head_valid = 1'b1;
            new_head_op    = sprite_op_e'(next_tag);
        end else begin
            new_head_valid = push;
            new_head_op    = push_entry.op;
        end
        state_d = new_head_valid ? state_for_op(new_head_op) : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sweep_q   <= '0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    assign busy    = (count != '0);
    assign cmd_err = cmd_err_q;

    sprite_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W),
        .TAG_W (2)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .next_tag  (next_tag),
        .count     (count)
    );

endmodule

// File: tb/tb_sprite_reg_writer.sv
// Self-checking bench for sprite_reg_writer against a queue-based command model.
module tb_sprite_reg_writer;

    localparam int OP_NOP_M = 0;
    localparam int OP_SET_M = 1;
    localparam int OP_CLR_M = 2;
    localparam int OP_CLA_M = 3;

    logic        clk;
    logic        reset;
    logic        write_window;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        cmd_err;

    sprite_reg_writer_if #(.ADDR_W(5)) cif ();

    sprite_reg_writer #(
        .SIZE_REG   (32),
        .NUM_REGS   (32),
        .ADDR_W     (5),
        .FIFO_DEPTH (4),
        .X_MAX      (640),
        .Y_MAX      (480)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd          (cif),
        .write_window (write_window),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .cmd_err      (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          op;
        int          addr;
        logic [31:0] word;
    } mcmd_t;

    mcmd_t       mq[$];
    int          sweep_idx;
    bit          err_pend;
    logic [31:0] exp_bank [32];
    logic [31:0] dut_bank [32];

    logic        exp_wr_en, exp_ready, exp_busy, exp_err;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;

    int checks;
    int errors;

    function automatic void model_eval();
        exp_ready = (mq.size() < 4);
        exp_busy  = (mq.size() != 0);
        exp_err   = err_pend;
        exp_wr_en = 1'b0;
        exp_addr  = '0;
        exp_data  = '0;
        if (!reset && mq.size() > 0 && write_window) begin
            exp_wr_en = 1'b1;
            if (mq[0].op == OP_CLA_M) begin
                exp_addr = 5'(sweep_idx);
                exp_data = 32'h0;
            end else begin
                exp_addr = 5'(mq[0].addr);
                exp_data = mq[0].word;
            end
        end
    endfunction

    function automatic void model_update();
        mcmd_t c;
        bit    had_room;
        int    x, y;
        if (reset) begin
            mq.delete();
            sweep_idx = 0;
            err_pend  = 1'b0;
            return;
        end
        had_room = (mq.size() < 4);
        if (exp_wr_en) begin
            exp_bank[exp_addr] = exp_data;
            if (mq[0].op == OP_CLA_M) begin
                sweep_idx++;
                if (sweep_idx == 32) begin
                    void'(mq.pop_front());
                    sweep_idx = 0;
                end
            end else begin
                void'(mq.pop_front());
            end
        end
        err_pend = 1'b0;
        if (cif.cmd_valid && had_room) begin
            x      = int'(cif.cmd_x);
            y      = int'(cif.cmd_y);
            c.op   = int'(cif.cmd_op);
            c.addr = int'(cif.cmd_addr);
            c.word = 32'h0;
            if (c.op == OP_SET_M) begin
                if (x >= 640 || y >= 480) begin
                    err_pend = 1'b1;
                end else begin
                    c.word = 32'h2000_0000 + 32'(x) * 32'd524288 + 32'(y) * 32'd512
                           + 32'(cif.cmd_offset);
                    mq.push_back(c);
                end
            end else if (c.op != OP_NOP_M) begin
                mq.push_back(c);
            end
        end
    endfunction

    task automatic drive(input bit v, input int op, input int addr,
                         input int x, input int y, input int off);
        cif.cmd_valid  = v;
        cif.cmd_op     = 2'(op);
        cif.cmd_addr   = 5'(addr);
        cif.cmd_x      = 10'(x);
        cif.cmd_y      = 10'(y);
        cif.cmd_offset = 9'(off);
    endtask

    task automatic idle_cmd();
        cif.cmd_valid = 1'b0;
    endtask

    task automatic advance();
        model_eval();
        if (wr_en === 1'b1) dut_bank[wr_addr] = wr_data;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        advance();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        write_window = 1'b1;
        idle_cmd();
        step();
        @(negedge clk);
        model_eval();
        checks++;
        if (wr_en !== 1'b0) begin
            errors++; $display("FAIL reset_cycle_wr_en: got %b want 0", wr_en);
        end
        advance();
        reset = 1'b0;
        @(negedge clk);
        model_eval();
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b0, 5'd0, 32'd0}) begin
            errors++; $display("FAIL reset_wr_bus: got en=%b a=%0d d=%h want 0/0/0", wr_en, wr_addr, wr_data);
        end
        checks++;
        if ({cif.cmd_ready, busy, cmd_err} !== 3'b100) begin
            errors++; $display("FAIL reset_status: got rdy/busy/err=%b want 100", {cif.cmd_ready, busy, cmd_err});
        end
        advance();
    endtask

    task automatic test_single_set();
        write_window = 1'b1;
        drive(1, OP_SET_M, 3, 100, 50, 7);
        @(negedge clk);
        model_eval();
        checks++;
        if (wr_en !== exp_wr_en) begin
            errors++; $display("FAIL single_accept_cycle_wr_en: got %b want %b", wr_en, exp_wr_en);
        end
        advance();
        idle_cmd();
        @(negedge clk);
        model_eval();
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {exp_wr_en, exp_addr, exp_data}) begin
            errors++; $display("FAIL single_write: got en=%b a=%0d d=%h want en=%b a=%0d d=%h",
                               wr_en, wr_addr, wr_data, exp_wr_en, exp_addr, exp_data);
        end
        checks++;
        if (busy !== exp_busy) begin
            errors++; $display("FAIL single_busy_during: got %b want %b", busy, exp_busy);
        end
        advance();
        @(negedge clk);
        model_eval();
        checks++;
        if ({busy, wr_en} !== {exp_busy, exp_wr_en}) begin
            errors++; $display("FAIL single_busy_after: got busy/en=%b want %b", {busy, wr_en}, {exp_busy, exp_wr_en});
        end
        advance();
    endtask

    task automatic test_fill_closed();
        write_window = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1, OP_SET_M, 8 + i, $urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 511));
            @(negedge clk);
            model_eval();
            checks++;
            if ({cif.cmd_ready, wr_en} !== {exp_ready, exp_wr_en}) begin
                errors++; $display("FAIL fill_push%0d: got rdy/en=%b want %b", i, {cif.cmd_ready, wr_en}, {exp_ready, exp_wr_en});
            end
            advance();
        end
        idle_cmd();
        write_window = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            model_eval();
            checks++;
            if ({wr_en, wr_addr, wr_data} !== {exp_wr_en, exp_addr, exp_data}) begin
                errors++; $display("FAIL fill_drain%0d: got en=%b a=%0d d=%h want en=%b a=%0d d=%h",
                                   i, wr_en, wr_addr, wr_data, exp_wr_en, exp_addr, exp_data);
            end
            advance();
        end
        @(negedge clk);
        model_eval();
        checks++;
        if ({busy, wr_en} !== {exp_busy, exp_wr_en}) begin
            errors++; $display("FAIL fill_done: got busy/en=%b want %b", {busy, wr_en}, {exp_busy, exp_wr_en});
        end
        advance();
    endtask

    task automatic test_reject_nop();
        int xs [4] = '{640, 0, 0, 1023};
        int ys [4] = '{0, 0, 480, 479};
        int ops[4] = '{OP_SET_M, OP_NOP_M, OP_SET_M, OP_SET_M};
        write_window = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(1, ops[i], 12, xs[i], ys[i], 5);
            else idle_cmd();
            if (i == 2) idle_cmd();
            if (i == 3) drive(1, ops[2], 12, xs[2], ys[2], 5);
            if (i == 4) drive(1, ops[3], 12, xs[3], ys[3], 5);
            @(negedge clk);
            model_eval();
            checks++;
            if ({cmd_err, wr_en, busy} !== {exp_err, exp_wr_en, exp_busy}) begin
                errors++; $display("FAIL reject_step%0d: got err/en/busy=%b want %b", i,
                                   {cmd_err, wr_en, busy}, {exp_err, exp_wr_en, exp_busy});
            end
            advance();
        end
    endtask

    task automatic test_sweep();
        int c;
        write_window = 1'b1;
        drive(1, OP_CLA_M, 0, 0, 0, 0);
        step();
        drive(1, OP_SET_M, 0, $urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 511));
        step();
        idle_cmd();
        c = 0;
        while ((mq.size() != 0) && (c < 80)) begin
            write_window = !((c >= 12) && (c < 15));
            @(negedge clk);
            model_eval();
            checks++;
            if (wr_en !== exp_wr_en || (exp_wr_en && {wr_addr, wr_data} !== {exp_addr, exp_data})) begin
                errors++; $display("FAIL sweep_cycle%0d: got en=%b a=%0d d=%h want en=%b a=%0d d=%h",
                                   c, wr_en, wr_addr, wr_data, exp_wr_en, exp_addr, exp_data);
            end
            advance();
            c++;
        end
        write_window = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL sweep_timeout_busy: got %b want 0", busy);
        end
        advance();
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (dut_bank[i] !== exp_bank[i]) begin
                errors++; $display("FAIL sweep_bank[%0d]: got %h want %h", i, dut_bank[i], exp_bank[i]);
            end
        end
        checks++;
        if (dut_bank[0] === 32'h0) begin
            errors++; $display("FAIL sweep_final_addr0: got %h want nonzero", dut_bank[0]);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int c;
        write_window = 1'b1;
        drive(1, OP_CLA_M, 0, 0, 0, 0);
        step();
        drive(1, OP_SET_M, 5, 20, 30, 40);
        step();
        idle_cmd();
        c = 0;
        while ((sweep_idx != 10) && (c < 40)) begin
            step();
            c++;
        end
        checks++;
        if (sweep_idx != 10 || busy !== 1'b1) begin
            errors++; $display("FAIL midreset_reach: got busy=%b idx=%0d want busy=1 idx=10", busy, sweep_idx);
        end
        reset = 1'b1;
        @(negedge clk);
        model_eval();
        checks++;
        if (wr_en !== 1'b0) begin
            errors++; $display("FAIL midreset_reset_cycle_wr_en: got %b want 0", wr_en);
        end
        advance();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            model_eval();
            checks++;
            if ({wr_en, busy, cif.cmd_ready} !== 3'b001) begin
                errors++; $display("FAIL midreset_after%0d: got en/busy/rdy=%b want 001", i, {wr_en, busy, cif.cmd_ready});
            end
            advance();
        end
        drive(1, OP_SET_M, 9, 321, 123, 45);
        step();
        idle_cmd();
        @(negedge clk);
        model_eval();
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {exp_wr_en, exp_addr, exp_data}) begin
            errors++; $display("FAIL midreset_new_cmd: got en=%b a=%0d d=%h want en=%b a=%0d d=%h",
                               wr_en, wr_addr, wr_data, exp_wr_en, exp_addr, exp_data);
        end
        advance();
        step();
    endtask

    task automatic test_back_to_back();
        write_window = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, (i == 1) ? OP_CLR_M : OP_SET_M, 16 + i,
                  $urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 511));
            step();
        end
        write_window = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1, OP_SET_M, 20 + i, $urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 511));
            @(negedge clk);
            model_eval();
            checks++;
            if ({cif.cmd_ready, wr_en, busy} !== {exp_ready, exp_wr_en, exp_busy} ||
                {wr_addr, wr_data} !== {exp_addr, exp_data}) begin
                errors++; $display("FAIL b2b_cycle%0d: got rdy=%b en=%b a=%0d d=%h want rdy=%b en=%b a=%0d d=%h",
                                   i, cif.cmd_ready, wr_en, wr_addr, wr_data, exp_ready, exp_wr_en, exp_addr, exp_data);
            end
            advance();
        end
        idle_cmd();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            model_eval();
            checks++;
            if (wr_en !== exp_wr_en || (exp_wr_en && {wr_addr, wr_data} !== {exp_addr, exp_data})) begin
                errors++; $display("FAIL b2b_drain%0d: got en=%b a=%0d d=%h want en=%b a=%0d d=%h",
                                   i, wr_en, wr_addr, wr_data, exp_wr_en, exp_addr, exp_data);
            end
            advance();
        end
    endtask

    task automatic test_random();
        int r, op;
        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 15);
            op = (r == 0) ? OP_NOP_M : (r == 1) ? OP_CLA_M : (r < 6) ? OP_CLR_M : OP_SET_M;
            write_window = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 1), op, $urandom_range(0, 31),
                  $urandom_range(0, 700), $urandom_range(0, 520), $urandom_range(0, 511));
            @(negedge clk);
            model_eval();
            checks++;
            if ({wr_en, cif.cmd_ready, busy, cmd_err} !== {exp_wr_en, exp_ready, exp_busy, exp_err}) begin
                errors++; $display("FAIL rand_ctrl%0d: got en/rdy/busy/err=%b want %b", i,
                                   {wr_en, cif.cmd_ready, busy, cmd_err}, {exp_wr_en, exp_ready, exp_busy, exp_err});
            end
            if (exp_wr_en) begin
                checks++;
                if ({wr_addr, wr_data} !== {exp_addr, exp_data}) begin
                    errors++; $display("FAIL rand_write%0d: got a=%0d d=%h want a=%0d d=%h",
                                       i, wr_addr, wr_data, exp_addr, exp_data);
                end
            end
            advance();
        end
        idle_cmd();
        write_window = 1'b1;
        for (int i = 0; (i < 300) && (mq.size() != 0 || err_pend); i++) step();
        @(negedge clk);
        model_eval();
        checks++;
        if ({busy, cmd_err} !== 2'b00) begin
            errors++; $display("FAIL rand_drain_idle: got busy/err=%b want 00", {busy, cmd_err});
        end
        advance();
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (dut_bank[i] !== exp_bank[i]) begin
                errors++; $display("FAIL rand_bank[%0d]: got %h want %h", i, dut_bank[i], exp_bank[i]);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        sweep_idx = 0;
        err_pend  = 1'b0;
        reset     = 1'b1;
        write_window = 1'b0;
        drive(0, OP_NOP_M, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            exp_bank[i] = 32'hDEAD_BEEF;
            dut_bank[i] = 32'hDEAD_BEEF;
        end
        #1;
        test_reset();
        test_single_set();
        test_fill_closed();
        test_reject_nop();
        test_sweep();
        test_reset_mid_sweep();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

endmodule
